// File: rtl/decode_sel_scheduler.sv
// Round-robin scheduler driving the 3-bit select of an 8-output decoder.
// One grant at a time, sel held stable, break-before-make dead time between grants.
module decode_sel_scheduler #(
  parameter int unsigned MAX_HOLD   = 16,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] sel,
  output logic       sel_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t      r_state;
  logic [2:0]  r_sel;
  logic        r_sel_valid;
  logic        r_timeout;
  logic [2:0]  r_ptr;
  logic [15:0] r_hold_cnt;
  logic [3:0]  r_gap_cnt;

  logic [2:0]  w_winner;
  logic        w_found;
  logic        w_req_sel;
  logic        w_hold_hit;

  // Scan from lowest to highest priority so the last match (ptr+1 side) wins.
  always_comb begin
    logic [2:0] idx;
    w_winner = r_ptr;
    w_found  = 1'b0;
    idx      = r_ptr;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = r_ptr + 3'(8 - k);
      if (req[idx]) begin
        w_winner = idx;
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_req_sel  = req[r_sel];
    w_hold_hit = (MAX_HOLD != 0) && (r_hold_cnt == 16'(MAX_HOLD));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_sel_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_ptr       <= 3'd7;
      r_hold_cnt  <= '0;
      r_gap_cnt   <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          r_sel_valid <= 1'b0;
          if (w_found) begin
            r_sel       <= w_winner;
            r_sel_valid <= 1'b1;
            r_ptr       <= w_winner;
            r_hold_cnt  <= 16'd1;
            r_state     <= GRANT;
          end
        end
        GRANT: begin
          if (done || !w_req_sel) begin
            r_sel_valid <= 1'b0;
            r_gap_cnt   <= 4'(GAP_CYCLES - 1);
            r_state     <= GAP;
          end else if (w_hold_hit) begin
            r_sel_valid <= 1'b0;
            r_timeout   <= 1'b1;
            r_gap_cnt   <= 4'(GAP_CYCLES - 1);
            r_state     <= GAP;
          end else if (r_hold_cnt != '1) begin
            r_hold_cnt <= r_hold_cnt + 16'd1;
          end
        end
        GAP: begin
          r_sel_valid <= 1'b0;
          if (r_gap_cnt == '0) begin
            r_state <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_sel_valid <= 1'b0;
        end
      endcase
    end
  end

  assign sel       = r_sel;
  assign sel_valid = r_sel_valid;
  assign timeout   = r_timeout;

endmodule
